instruction_fetch_controller: RTL and testbench

Sequences the instruction ROM for the 16-bit accumulator pipeline. It owns the program counter, drives the ROM address, and registers the fetched word into the IF/ID stage register. It also holds fetch on downstream stalls and, on a taken branch, redirects the PC and inserts a fixed number of hardware NOP bubbles. This lets programs drop the hand-placed NOP padding after branches. It sits between the combinational instruction ROM and the decode stage.

---
 rtl/instruction_fetch_controller.sv | 92 +++++++++
 tb/tb_instruction_fetch_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: owns the PC and drives the ROM address.
// It registers the fetched word into the IF/ID register and holds fetch on stalls.
// On a taken branch it redirects the PC and emits FLUSH_SLOTS bubbles before
// the word at the branch target appears.
module instruction_fetch_controller #(
  parameter int unsigned         ADDR_W       = 10,
  parameter int unsigned         INSTR_W      = 16,
  parameter logic [INSTR_W-1:0]  NOP_INSTR    = '0,
  parameter logic [ADDR_W-1:0]   RESET_VECTOR = '0,
  parameter int unsigned         FLUSH_SLOTS  = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStall,
  input  logic               iBranchTaken,
  input  logic [ADDR_W-1:0]  iBranchTarget,
  output logic [ADDR_W-1:0]  oRomAddress,
  input  logic [INSTR_W-1:0] iRomInstruction,
  output logic [INSTR_W-1:0] oInstruction,
  output logic [ADDR_W-1:0]  oPC,
  output logic               oValid,
  output logic               oFlushing
);

  typedef enum logic {RUN, REDIRECT} state_t;

  // The branch edge itself supplies the first bubble, so the counter starts one
  // below the slot count. The REDIRECT cycle that sees zero fetches the target,
  // which makes the total exactly FLUSH_SLOTS bubbles.
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_SLOTS - 1);

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [3:0]          bubble_cnt;

  assign oRomAddress = pc;

  // Fetch FSM: PC sequencing, IF/ID register, and bubble insertion after redirects
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= RUN;
      pc           <= RESET_VECTOR;
      bubble_cnt   <= '0;
      oInstruction <= NOP_INSTR;
      oPC          <= '0;
      oValid       <= 1'b0;
      oFlushing    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (iBranchTaken) begin
            // The word at the old PC is dropped in favour of a bubble
            pc           <= iBranchTarget;
            oInstruction <= NOP_INSTR;
            oPC          <= '0;
            oValid       <= 1'b0;
            bubble_cnt   <= FLUSH_INIT;
            state        <= REDIRECT;
            oFlushing    <= 1'b1;
          end else if (!iStall) begin
            oInstruction <= iRomInstruction;
            oPC          <= pc;
            oValid       <= 1'b1;
            pc           <= pc + 1'b1;
          end
        end
        REDIRECT: begin
          // A branch pulse here is ignored because bubbles cannot branch
          if (!iStall) begin
            if (bubble_cnt == 4'd0) begin
              oInstruction <= iRomInstruction;
              oPC          <= pc;
              oValid       <= 1'b1;
              pc           <= pc + 1'b1;
              state        <= RUN;
              oFlushing    <= 1'b0;
            end else begin
              bubble_cnt   <= bubble_cnt - 4'd1;
              oInstruction <= NOP_INSTR;
              oValid       <= 1'b0;
            end
          end
        end
        default: begin
          state     <= RUN;
          oFlushing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: directed scenarios followed by random
// stall/branch/reset traffic, checked against a cycle-level reference model.
module tb_instruction_fetch_controller;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP = 16'hFC00;
  localparam logic [ADDR_W-1:0]  RV  = '0;
  localparam int unsigned FS = 3;

  logic               Clock = 1'b0;
  logic               Reset;
  logic               iStall;
  logic               iBranchTaken;
  logic [ADDR_W-1:0]  iBranchTarget;
  logic [ADDR_W-1:0]  oRomAddress;
  logic [INSTR_W-1:0] iRomInstruction;
  logic [INSTR_W-1:0] oInstruction;
  logic [ADDR_W-1:0]  oPC;
  logic               oValid;
  logic               oFlushing;

  logic [INSTR_W-1:0] rom [1024];

  int checks = 0;
  int failures = 0;

  // Reference model state: owed counts bubble cycles still to be shown,
  // including the one currently on the output.
  logic [ADDR_W-1:0]  m_pc;
  int                 m_owed;
  logic [INSTR_W-1:0] m_instr;
  logic [ADDR_W-1:0]  m_opc;
  logic               m_valid;

  instruction_fetch_controller #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP),
    .RESET_VECTOR(RV), .FLUSH_SLOTS(FS)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iStall(iStall),
    .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
    .oRomAddress(oRomAddress), .iRomInstruction(iRomInstruction),
    .oInstruction(oInstruction), .oPC(oPC), .oValid(oValid),
    .oFlushing(oFlushing)
  );

  assign iRomInstruction = rom[oRomAddress];

  always #5 Clock = ~Clock;

  // Upstream must never pulse a branch while the controller is flushing
  always @(posedge Clock) begin
    if (!Reset) assert (!(iBranchTaken && oFlushing)) else $error("branch pulsed during redirect");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_fetch();
    m_instr = rom[m_pc];
    m_opc   = m_pc;
    m_valid = 1'b1;
    m_pc    = m_pc + 1'b1;
  endtask

  // One clock: apply inputs, advance the model at the edge, compare after it
  task automatic step(input logic rst, input logic stall, input logic br,
                      input logic [ADDR_W-1:0] tgt);
    Reset = rst; iStall = stall; iBranchTaken = br; iBranchTarget = tgt;
    @(posedge Clock);
    if (rst) begin
      m_pc = RV; m_owed = 0; m_instr = NOP; m_opc = '0; m_valid = 1'b0;
    end else if (br && m_owed == 0) begin
      m_pc = tgt; m_owed = FS; m_instr = NOP; m_opc = '0; m_valid = 1'b0;
    end else if (!stall) begin
      if (m_owed > 0) begin
        m_owed--;
        if (m_owed > 0) begin
          m_instr = NOP; m_valid = 1'b0;
        end else begin
          model_fetch();
        end
      end else begin
        model_fetch();
      end
    end
    #1;
    chk("rom_address", oRomAddress, m_pc);
    chk("valid", oValid, m_valid);
    chk("flushing", oFlushing, m_owed > 0);
    chk("pc", oPC, m_opc);
    chk("instruction", oInstruction, m_instr);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      rom[i] = {6'($urandom_range(0, 62)), 10'(i)};
    Reset = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = '0;
    m_pc = RV; m_owed = 0; m_instr = NOP; m_opc = '0; m_valid = 1'b0;

    // Reset and straight-line fetch
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_valid", oValid, 0);
    chk("reset_flush", oFlushing, 0);
    chk("reset_addr", oRomAddress, RV);
    chk("reset_instr", oInstruction, NOP);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      chk("seq_pc", oPC, i);
      chk("seq_instr", oInstruction, rom[i]);
      chk("seq_valid", oValid, 1);
    end

    // Stall at PC=4
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      chk("stall_pc", oPC, 3);
      chk("stall_addr", oRomAddress, 4);
    end
    step(0, 0, 0, 0);
    chk("unstall_pc", oPC, 4);

    // Branch from PC=10 to 7
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("pre_branch_addr", oRomAddress, 10);
    step(0, 0, 1, 10'd7);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step(0, 0, 0, 0);
      chk("br_bubble_valid", oValid, 0);
      chk("br_bubble_instr", oInstruction, NOP);
      chk("br_bubble_flush", oFlushing, 1);
    end
    step(0, 0, 0, 0);
    chk("br_target_pc", oPC, 7);
    chk("br_target_valid", oValid, 1);
    chk("br_target_flush", oFlushing, 0);
    step(0, 0, 0, 0);
    chk("br_next_pc", oPC, 8);

    // Stall inside the flush: five bubbles in total
    step(0, 0, 1, 10'd20);
    step(0, 0, 0, 0);
    chk("sf_bubble2", oValid, 0);
    step(0, 1, 0, 0);
    chk("sf_bubble3", oValid, 0);
    step(0, 1, 0, 0);
    chk("sf_bubble4", oValid, 0);
    step(0, 0, 0, 0);
    chk("sf_bubble5", oValid, 0);
    step(0, 0, 0, 0);
    chk("sf_target_pc", oPC, 20);
    chk("sf_target_valid", oValid, 1);

    // PC wrap
    step(0, 0, 1, 10'd1022);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      chk("wrap_pc", oPC, (1022 + i) % 1024);
    end

    // Reset on the second bubble aborts the flush
    step(0, 0, 1, 10'd100);
    step(1, 0, 0, 0);
    chk("rst_flush_flushing", oFlushing, 0);
    chk("rst_flush_addr", oRomAddress, RV);
    chk("rst_flush_valid", oValid, 0);
    step(0, 0, 0, 0);
    chk("rst_flush_pc0", oPC, 0);
    step(0, 0, 0, 0);
    chk("rst_flush_pc1", oPC, 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic r, s, b;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = (m_owed == 0) && ($urandom_range(0, 11) == 0);
      step(r, s, b, 10'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
